// File: rtl/vga_pkg.sv
// Shared SVGA scanout definitions: 800x600@60 timing defaults, VRAM widths,
// the IRGB-to-12-bit colour expansion and the VRAM port arbiter states.
package vga_pkg;

   localparam int SVGA_H_ACTIVE = 800;
   localparam int SVGA_H_FP     = 40;
   localparam int SVGA_H_SYNC   = 128;
   localparam int SVGA_H_BP     = 88;
   localparam int SVGA_V_ACTIVE = 600;
   localparam int SVGA_V_FP     = 1;
   localparam int SVGA_V_SYNC   = 4;
   localparam int SVGA_V_BP     = 23;

   localparam int VRAM_ADDR_W = 19;
   localparam int VRAM_DATA_W = 4;

   // Counter widths sized for the full 1056 x 628 raster.
   localparam int HCNT_W = 11;
   localparam int VCNT_W = 10;

   typedef enum logic [1:0] {
      ARB_SCAN   = 2'd0,
      ARB_VBLANK = 2'd1,
      ARB_GRANT  = 2'd2
   } arb_state_e;

   // Each 4-bit channel is {C,I,C,I}, so intensity lifts every colour evenly.
   function automatic logic [11:0] irgb_to_rgb12(input logic [3:0] irgb);
      logic in, rd, gr, bl;
      {in, rd, gr, bl} = irgb;
      return {rd, in, rd, in, gr, in, gr, in, bl, in, bl, in};
   endfunction

endpackage

// File: rtl/m_vga_timing.sv
// Raster counters for the scanout engine plus the raw (undelayed) sync,
// visible-area and frame-start flags decoded from them.
module m_vga_timing
   import vga_pkg::*;
#(
   parameter int H_ACTIVE = SVGA_H_ACTIVE,
   parameter int H_FP     = SVGA_H_FP,
   parameter int H_SYNC   = SVGA_H_SYNC,
   parameter int H_BP     = SVGA_H_BP,
   parameter int V_ACTIVE = SVGA_V_ACTIVE,
   parameter int V_FP     = SVGA_V_FP,
   parameter int V_SYNC   = SVGA_V_SYNC,
   parameter int V_BP     = SVGA_V_BP
) (
   input  logic              clk,
   input  logic              rst,
   output logic [HCNT_W-1:0] hcnt,
   output logic [VCNT_W-1:0] vcnt,
   output logic              line_end,
   output logic              hsync_raw,
   output logic              vsync_raw,
   output logic              active_raw,
   output logic              frame_start_raw
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [HCNT_W-1:0] H_LAST   = HCNT_W'(H_TOTAL - 1);
   localparam logic [HCNT_W-1:0] H_VIS    = HCNT_W'(H_ACTIVE);
   localparam logic [HCNT_W-1:0] HS_BEGIN = HCNT_W'(H_ACTIVE + H_FP);
   localparam logic [HCNT_W-1:0] HS_END   = HCNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
   localparam logic [VCNT_W-1:0] V_LAST   = VCNT_W'(V_TOTAL - 1);
   localparam logic [VCNT_W-1:0] V_VIS    = VCNT_W'(V_ACTIVE);
   localparam logic [VCNT_W-1:0] VS_BEGIN = VCNT_W'(V_ACTIVE + V_FP);
   localparam logic [VCNT_W-1:0] VS_END   = VCNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

   assign line_end = (hcnt == H_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hcnt <= '0;
         vcnt <= '0;
      end else if (line_end) begin
         hcnt <= '0;
         vcnt <= (vcnt == V_LAST) ? '0 : vcnt + 1'b1;
      end else begin
         hcnt <= hcnt + 1'b1;
      end
   end

   assign hsync_raw       = !((hcnt >= HS_BEGIN) && (hcnt <= HS_END));
   assign vsync_raw       = !((vcnt >= VS_BEGIN) && (vcnt <= VS_END));
   assign active_raw      = (hcnt < H_VIS) && (vcnt < V_VIS);
   assign frame_start_raw = (hcnt == '0) && (vcnt == '0);

endmodule

// File: rtl/m_vram_scanout.sv
// VRAM read-side scanout: SVGA timing, sequential read addresses, IRGB colour
// expansion with matched sync delay, and the vblank-only writer arbiter.
// Build option SCANOUT_TESTPATTERN_EN replaces VRAM pixels with colour bars.
module m_vram_scanout
   import vga_pkg::*;
#(
   parameter int H_ACTIVE   = SVGA_H_ACTIVE,
   parameter int H_FP       = SVGA_H_FP,
   parameter int H_SYNC     = SVGA_H_SYNC,
   parameter int H_BP       = SVGA_H_BP,
   parameter int V_ACTIVE   = SVGA_V_ACTIVE,
   parameter int V_FP       = SVGA_V_FP,
   parameter int V_SYNC     = SVGA_V_SYNC,
   parameter int V_BP       = SVGA_V_BP,
   parameter int ADDR_WIDTH = VRAM_ADDR_W,
   parameter int DATA_WIDTH = VRAM_DATA_W
) (
   input  logic                  clk,
   input  logic                  w_rst,
   output logic [ADDR_WIDTH-1:0] o_addr,
   input  logic [DATA_WIDTH-1:0] i_data,
   output logic                  o_hsync,
   output logic                  o_vsync,
   output logic [3:0]            o_red,
   output logic [3:0]            o_green,
   output logic [3:0]            o_blue,
   output logic                  o_active,
   output logic                  o_frame_start,
   input  logic                  i_wr_req,
   output logic                  o_wr_gnt,
   output arb_state_e            o_arb_state
);

   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [VCNT_W-1:0] V_PRE_BLANK = VCNT_W'(V_ACTIVE - 1);
   localparam logic [VCNT_W-1:0] V_LAST      = VCNT_W'(V_TOTAL - 1);

   logic [HCNT_W-1:0] hcnt;
   logic [VCNT_W-1:0] vcnt;
   logic              line_end;
   logic              hsync_raw;
   logic              vsync_raw;
   logic              active_raw;
   logic              frame_start_raw;

   m_vga_timing #(
      .H_ACTIVE (H_ACTIVE),
      .H_FP     (H_FP),
      .H_SYNC   (H_SYNC),
      .H_BP     (H_BP),
      .V_ACTIVE (V_ACTIVE),
      .V_FP     (V_FP),
      .V_SYNC   (V_SYNC),
      .V_BP     (V_BP)
   ) u_timing (
      .clk             (clk),
      .rst             (w_rst),
      .hcnt            (hcnt),
      .vcnt            (vcnt),
      .line_end        (line_end),
      .hsync_raw       (hsync_raw),
      .vsync_raw       (vsync_raw),
      .active_raw      (active_raw),
      .frame_start_raw (frame_start_raw)
   );

   // Stage 1 issues the address; stages 1-2 carry the raster flags while the
   // VRAM answers, and stage 3 registers colour and flags together.
   logic act_p1, act_p2;
   logic hs_p1, hs_p2;
   logic vs_p1, vs_p2;
   logic fs_p1, fs_p2;

   always_ff @(posedge clk or posedge w_rst) begin
      if (w_rst) begin
         o_addr <= '0;
         act_p1 <= 1'b0;
         act_p2 <= 1'b0;
         hs_p1  <= 1'b1;
         hs_p2  <= 1'b1;
         vs_p1  <= 1'b1;
         vs_p2  <= 1'b1;
         fs_p1  <= 1'b0;
         fs_p2  <= 1'b0;
      end else begin
         // Restarting at (0,0) lets the address simply count visible pixels.
         if (frame_start_raw) begin
            o_addr <= '0;
         end else if (active_raw) begin
            o_addr <= o_addr + 1'b1;
         end
         act_p1 <= active_raw;
         act_p2 <= act_p1;
         hs_p1  <= hsync_raw;
         hs_p2  <= hs_p1;
         vs_p1  <= vsync_raw;
         vs_p2  <= vs_p1;
         fs_p1  <= frame_start_raw;
         fs_p2  <= fs_p1;
      end
   end

   logic [3:0]  pixel;
   logic [11:0] rgb;

`ifdef SCANOUT_TESTPATTERN_EN
   logic [3:0] bar_p1, bar_p2;

   always_ff @(posedge clk or posedge w_rst) begin
      if (w_rst) begin
         bar_p1 <= '0;
         bar_p2 <= '0;
      end else begin
         bar_p1 <= hcnt[9:6];
         bar_p2 <= bar_p1;
      end
   end

   assign pixel = bar_p2;
`else
   assign pixel = i_data[3:0];
`endif

   assign rgb = irgb_to_rgb12(pixel);

   always_ff @(posedge clk or posedge w_rst) begin
      if (w_rst) begin
         o_red         <= '0;
         o_green       <= '0;
         o_blue        <= '0;
         o_active      <= 1'b0;
         o_hsync       <= 1'b1;
         o_vsync       <= 1'b1;
         o_frame_start <= 1'b0;
      end else begin
         if (act_p2) begin
            {o_red, o_green, o_blue} <= rgb;
         end else begin
            {o_red, o_green, o_blue} <= '0;
         end
         o_active      <= act_p2;
         o_hsync       <= hs_p2;
         o_vsync       <= vs_p2;
         o_frame_start <= fs_p2;
      end
   end

   arb_state_e arb_state;
   logic       vblank_entry;
   logic       last_line;
   logic       revoke;

   // Enter VBLANK on the same edge that vcnt steps onto V_ACTIVE.
   assign vblank_entry = line_end && (vcnt == V_PRE_BLANK);
   assign last_line    = (vcnt == V_LAST);
   assign revoke       = last_line && (hcnt == '0);

   always_ff @(posedge clk or posedge w_rst) begin
      if (w_rst) begin
         arb_state <= ARB_SCAN;
         o_wr_gnt  <= 1'b0;
      end else if (revoke && (arb_state != ARB_SCAN)) begin
         // One full line of margin before visible reads resume.
         arb_state <= ARB_SCAN;
         o_wr_gnt  <= 1'b0;
      end else begin
         case (arb_state)
            ARB_SCAN: begin
               if (vblank_entry) begin
                  arb_state <= ARB_VBLANK;
               end
            end
            ARB_VBLANK: begin
               if (i_wr_req && !last_line) begin
                  arb_state <= ARB_GRANT;
                  o_wr_gnt  <= 1'b1;
               end
            end
            ARB_GRANT: begin
               if (!i_wr_req) begin
                  arb_state <= ARB_VBLANK;
                  o_wr_gnt  <= 1'b0;
               end
            end
            default: begin
               arb_state <= ARB_SCAN;
               o_wr_gnt  <= 1'b0;
            end
         endcase
      end
   end

   assign o_arb_state = arb_state;

endmodule
